// File: rtl/draw_scheduler_if.sv
// Bundle between the VGA draw scheduler and its N drawers.
// The scheduler takes the slave modport; the drawers/plot sink side takes master.
interface draw_scheduler_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [8*N-1:0] x_in;
    logic [7*N-1:0] y_in;
    logic [9*N-1:0] colour_in;

    logic [N-1:0]   go;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [8:0]     colour;
    logic           plot;
    logic           busy;
    logic [GW-1:0]  grant_id;
    logic           frame_done;
    logic           timeout;

    modport master (
        output req, done, x_in, y_in, colour_in,
        input  go, x, y, colour, plot, busy, grant_id, frame_done, timeout
    );

    modport slave (
        input  req, done, x_in, y_in, colour_in,
        output go, x, y, colour, plot, busy, grant_id, frame_done, timeout
    );
endinterface

// File: rtl/draw_scheduler.sv
// Round-robin arbiter sharing one VGA plot port between N drawers.
// Each drawer is held in reset (go=0) until granted, then muxed onto x/y/colour.
module draw_scheduler #(
    parameter int unsigned N          = 4,
    parameter int unsigned PLOT_DELAY = 2,
    parameter int unsigned MAX_CYCLES = 8192
) (
    input  logic            clk,
    input  logic            reset,
    draw_scheduler_if.slave bus
);
    localparam int unsigned GW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WDW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int unsigned DW  = (PLOT_DELAY > 1) ? $clog2(PLOT_DELAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WARM, S_DRAW, S_RELEASE
    } state_t;

    state_t           r_state, w_next;
    logic [N-1:0]     r_pending, r_go;
    logic [GW-1:0]    r_rr_ptr, r_grant, w_winner;
    logic [WDW-1:0]   r_wd;
    logic [DW-1:0]    r_warm;
    logic             r_plot, r_busy, r_frame_done, r_timeout;
    logic             w_fin_ok, w_fin_to, w_found, w_done_g, w_wd_hit;
    logic [2*N-1:0]   w_rot;
    logic [N-1:0]     w_onehot, w_clear;
    logic [7:0]       w_x;
    logic [6:0]       w_y;
    logic [8:0]       w_c;

    // First pending drawer at or after rr_ptr, wrapping mod N
    always_comb begin
        int unsigned idx;
        idx      = 0;
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        w_rot    = {r_pending, r_pending} >> r_rr_ptr;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                idx = 32'(r_rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                w_winner = GW'(idx);
                w_found  = 1'b1;
            end
        end
    end

    // Select the granted drawer's pixel and done flag
    always_comb begin
        w_done_g = 1'b0;
        w_x      = '0;
        w_y      = '0;
        w_c      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (r_grant == GW'(k)) begin
                w_done_g = bus.done[k];
                w_x      = bus.x_in[8*k +: 8];
                w_y      = bus.y_in[7*k +: 7];
                w_c      = bus.colour_in[9*k +: 9];
            end
        end
    end

    assign w_onehot = N'(1) << r_grant;
    assign w_clear  = (r_state == S_ARM) ? w_onehot : '0;
    assign w_wd_hit = (r_wd == WDW'(MAX_CYCLES - 1));

    always_comb begin
        w_next   = r_state;
        w_fin_ok = 1'b0;
        w_fin_to = 1'b0;
        case (r_state)
            S_IDLE:    if (|r_pending) w_next = S_ARM;
            S_ARM:     w_next = S_WARM;
            S_WARM: begin
                if (w_wd_hit) begin
                    w_next   = S_RELEASE;
                    w_fin_to = 1'b1;
                end else if (r_warm == DW'(PLOT_DELAY - 1)) begin
                    w_next = S_DRAW;
                end
            end
            S_DRAW: begin
                // done on the last pixel wins over a coincident watchdog expiry
                if (w_done_g) begin
                    w_next   = S_RELEASE;
                    w_fin_ok = 1'b1;
                end else if (w_wd_hit) begin
                    w_next   = S_RELEASE;
                    w_fin_to = 1'b1;
                end
            end
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_wd         <= '0;
            r_warm       <= '0;
            r_go         <= '0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pending <= (r_pending & ~w_clear) | bus.req;
            if (r_state == S_IDLE && w_next == S_ARM) r_grant <= w_winner;
            if (r_state == S_RELEASE)
                r_rr_ptr <= (r_grant == GW'(N - 1)) ? '0 : r_grant + GW'(1);
            if (r_state == S_ARM)
                r_wd <= '0;
            else if (r_state == S_WARM || r_state == S_DRAW)
                r_wd <= r_wd + WDW'(1);
            if (r_state == S_ARM)       r_warm <= '0;
            else if (r_state == S_WARM) r_warm <= r_warm + DW'(1);
            // Outputs follow the state being entered, so they align with it
            r_go         <= (w_next == S_WARM || w_next == S_DRAW) ? w_onehot : '0;
            r_plot       <= (w_next == S_DRAW);
            r_busy       <= (w_next != S_IDLE);
            r_frame_done <= w_fin_ok;
            r_timeout    <= w_fin_to;
        end
    end

    assign bus.go         = r_go;
    assign bus.plot       = r_plot;
    assign bus.busy       = r_busy;
    assign bus.grant_id   = r_grant;
    assign bus.frame_done = r_frame_done;
    assign bus.timeout    = r_timeout;
    assign bus.x          = r_plot ? w_x : '0;
    assign bus.y          = r_plot ? w_y : '0;
    assign bus.colour     = r_plot ? w_c : '0;
endmodule
